// File: rtl/aec_param_calc.sv
// aec_param_calc
//   ASCII infix calculator. Characters arrive one per cycle, are tokenised
//   into multi-digit operands and operators, converted to postfix with a
//   shunting-yard pass, and the postfix stream is then evaluated. A single
//   stack serves as the operator stack during conversion and as the operand
//   stack during evaluation. All arithmetic wraps modulo 2^DATA_W.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   ready     ascii_in holds a character this cycle (taken only when idle)
//   ascii_in  input character
//   busy      high from the cycle after '=' until the cycle valid pulses
//   valid     one-cycle pulse, result/error final
//   error     qualified by valid, 1 = expression rejected
//   result    qualified by valid, forced to 0 when error=1
//
// Handshake: a character is consumed on a rising edge where ready=1 and the
// block is in its receive state (busy=0, valid=0); otherwise it is dropped.
module aec_param_calc #(
  parameter int DATA_W      = 16,
  parameter int MAX_TOK     = 32,
  parameter int STACK_DEPTH = 16,
  parameter int RADIX       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [7:0]        ascii_in,
  output logic              busy,
  output logic              valid,
  output logic              error,
  output logic [DATA_W-1:0] result
);

  localparam int TW = $clog2(MAX_TOK + 1);
  localparam int TI = $clog2(MAX_TOK);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int SI = $clog2(STACK_DEPTH);
  localparam logic [TW:0]       TOK_MAX = (TW + 1)'(MAX_TOK);
  localparam logic [SW-1:0]     STK_MAX = SW'(STACK_DEPTH);
  localparam logic [DATA_W-1:0] RAD_W   = DATA_W'(RADIX);

  // Operator codes, kept in the low bits of a token/stack word.
  localparam logic [2:0] OP_LP  = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_RP  = 3'd4;

  typedef enum logic [2:0] {S_RECV, S_CONVERT, S_FLUSH, S_EVAL, S_DONE} state_t;
  state_t state, next_state;

  logic              tok_is_op [MAX_TOK];
  logic [DATA_W-1:0] tok_val   [MAX_TOK];
  logic              pf_is_op  [MAX_TOK];
  logic [DATA_W-1:0] pf_val    [MAX_TOK];
  logic [DATA_W-1:0] stack     [STACK_DEPTH];

  logic [TW-1:0]     tok_cnt, tok_idx, pf_cnt, pf_idx;
  logic [SW-1:0]     sp;
  logic [DATA_W-1:0] acc;
  logic              acc_valid, err;

  function automatic logic [1:0] prec(input logic [2:0] op);
    return (op == OP_MUL) ? 2'd2 : 2'd1;
  endfunction

  // Character decode
  logic       rx_digit, rx_op, rx_close, rx_eq, rx_bad;
  logic [3:0] rx_dval;
  logic [2:0] rx_opcode;

  always_comb begin
    rx_digit  = 1'b0;
    rx_dval   = 4'd0;
    rx_op     = 1'b0;
    rx_opcode = OP_LP;
    rx_close  = 1'b0;
    rx_eq     = 1'b0;
    rx_bad    = 1'b0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      rx_digit = 1'b1;
      rx_dval  = 4'(ascii_in - 8'h30);
    end else if (RADIX == 16 && ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      rx_digit = 1'b1;
      rx_dval  = 4'(ascii_in - 8'h57);
    end else begin
      case (ascii_in)
        "+":     begin rx_op = 1'b1; rx_opcode = OP_ADD; rx_close = 1'b1; end
        "-":     begin rx_op = 1'b1; rx_opcode = OP_SUB; rx_close = 1'b1; end
        "*":     begin rx_op = 1'b1; rx_opcode = OP_MUL; rx_close = 1'b1; end
        "(":     begin rx_op = 1'b1; rx_opcode = OP_LP;  rx_close = 1'b1; end
        ")":     begin rx_op = 1'b1; rx_opcode = OP_RP;  rx_close = 1'b1; end
        " ":     rx_close = 1'b1;
        "=":     begin rx_close = 1'b1; rx_eq = 1'b1; end
        default: rx_bad = 1'b1;
      endcase
    end
  end

  logic              accept, store_opnd, opnd_ok, op_ok;
  logic [TW:0]       op_slot;
  logic [DATA_W-1:0] acc_next;

  // A closing character may store two tokens in one cycle: the pending
  // operand and then the operator itself, each capacity-checked.
  assign accept     = (state == S_RECV) && ready;
  assign store_opnd = accept && rx_close && acc_valid;
  assign opnd_ok    = {1'b0, tok_cnt} < TOK_MAX;
  assign op_slot    = {1'b0, tok_cnt} + (TW + 1)'(store_opnd);
  assign op_ok      = op_slot < TOK_MAX;
  assign acc_next   = acc * RAD_W + DATA_W'(rx_dval);

  // Views of current token, postfix entry and stack top
  logic [TI-1:0]     tok_i, pf_i;
  logic [SI-1:0]     top_i, nos_i;
  logic              cur_op, pfe_op;
  logic [DATA_W-1:0] cur_val, pfe_val, top_val, nos_val;

  assign tok_i   = tok_idx[TI-1:0];
  assign pf_i    = pf_idx[TI-1:0];
  assign top_i   = SI'(sp - SW'(1));
  assign nos_i   = SI'(sp - SW'(2));
  assign cur_op  = tok_is_op[tok_i];
  assign cur_val = tok_val[tok_i];
  assign pfe_op  = pf_is_op[pf_i];
  assign pfe_val = pf_val[pf_i];
  assign top_val = stack[top_i];
  assign nos_val = stack[nos_i];

  // Per-state action decode
  logic              push_en, pop_en, pf_wr_en, pf_wr_op, tok_adv, pf_adv;
  logic              ev_en, step_err;
  logic [DATA_W-1:0] push_val, pf_wr_val, ev_res;

  always_comb begin
    next_state = state;
    push_en    = 1'b0;
    push_val   = '0;
    pop_en     = 1'b0;
    pf_wr_en   = 1'b0;
    pf_wr_op   = 1'b0;
    pf_wr_val  = '0;
    tok_adv    = 1'b0;
    pf_adv     = 1'b0;
    ev_en      = 1'b0;
    ev_res     = '0;
    step_err   = 1'b0;
    case (state)
      S_RECV: if (accept && rx_eq) next_state = S_CONVERT;
      S_CONVERT: begin
        if (err) begin
          next_state = S_DONE;
        end else if (tok_idx == tok_cnt) begin
          next_state = S_FLUSH;
        end else if (!cur_op) begin
          pf_wr_en  = 1'b1;
          pf_wr_val = cur_val;
          tok_adv   = 1'b1;
        end else if (cur_val[2:0] == OP_LP) begin
          if (sp == STK_MAX) step_err = 1'b1;
          else begin push_en = 1'b1; push_val = cur_val; tok_adv = 1'b1; end
        end else if (cur_val[2:0] == OP_RP) begin
          if (sp == '0) begin
            step_err = 1'b1;
          end else if (top_val[2:0] == OP_LP) begin
            pop_en  = 1'b1;
            tok_adv = 1'b1;
          end else begin
            pop_en = 1'b1; pf_wr_en = 1'b1; pf_wr_op = 1'b1; pf_wr_val = top_val;
          end
        end else begin
          // Pop one higher-or-equal operator per cycle; the token index
          // only advances once the incoming operator is pushed.
          if (sp != '0 && top_val[2:0] != OP_LP &&
              prec(top_val[2:0]) >= prec(cur_val[2:0])) begin
            pop_en = 1'b1; pf_wr_en = 1'b1; pf_wr_op = 1'b1; pf_wr_val = top_val;
          end else if (sp == STK_MAX) begin
            step_err = 1'b1;
          end else begin
            push_en = 1'b1; push_val = cur_val; tok_adv = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (err) next_state = S_DONE;
        else if (sp == '0) next_state = S_EVAL;
        else if (top_val[2:0] == OP_LP) step_err = 1'b1;
        else begin
          pop_en = 1'b1; pf_wr_en = 1'b1; pf_wr_op = 1'b1; pf_wr_val = top_val;
        end
      end
      S_EVAL: begin
        if (err) begin
          next_state = S_DONE;
        end else if (pf_idx == pf_cnt) begin
          step_err   = (sp != SW'(1));
          next_state = S_DONE;
        end else if (!pfe_op) begin
          if (sp == STK_MAX) step_err = 1'b1;
          else begin push_en = 1'b1; push_val = pfe_val; pf_adv = 1'b1; end
        end else if (sp < SW'(2)) begin
          step_err = 1'b1;
        end else begin
          ev_en  = 1'b1;
          pf_adv = 1'b1;
          case (pfe_val[2:0])
            OP_ADD:  ev_res = nos_val + top_val;
            OP_SUB:  ev_res = nos_val - top_val;
            default: ev_res = nos_val * top_val;
          endcase
        end
      end
      S_DONE:  next_state = S_RECV;
      default: next_state = S_RECV;
    endcase
    if (step_err) next_state = S_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RECV;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt   <= '0;
      tok_idx   <= '0;
      pf_cnt    <= '0;
      pf_idx    <= '0;
      sp        <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < MAX_TOK; i++) begin
        tok_is_op[i] <= 1'b0;
        tok_val[i]   <= '0;
        pf_is_op[i]  <= 1'b0;
        pf_val[i]    <= '0;
      end
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (state == S_DONE) begin
      tok_cnt   <= '0;
      tok_idx   <= '0;
      pf_cnt    <= '0;
      pf_idx    <= '0;
      sp        <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        if (rx_digit) begin
          acc       <= acc_next;
          acc_valid <= 1'b1;
        end else if (rx_close) begin
          acc       <= '0;
          acc_valid <= 1'b0;
        end
        if (store_opnd && opnd_ok) begin
          tok_is_op[tok_cnt[TI-1:0]] <= 1'b0;
          tok_val[tok_cnt[TI-1:0]]   <= acc;
        end
        if (rx_op && op_ok) begin
          tok_is_op[op_slot[TI-1:0]] <= 1'b1;
          tok_val[op_slot[TI-1:0]]   <= DATA_W'(rx_opcode);
        end
        tok_cnt <= tok_cnt + TW'(store_opnd && opnd_ok) + TW'(rx_op && op_ok);
        if (rx_bad || (store_opnd && !opnd_ok) || (rx_op && !op_ok)) err <= 1'b1;
      end
      if (step_err) err <= 1'b1;
      if (tok_adv)  tok_idx <= tok_idx + TW'(1);
      if (pf_adv)   pf_idx  <= pf_idx + TW'(1);
      if (pf_wr_en) begin
        pf_is_op[pf_cnt[TI-1:0]] <= pf_wr_op;
        pf_val[pf_cnt[TI-1:0]]   <= pf_wr_val;
        pf_cnt <= pf_cnt + TW'(1);
      end
      if (ev_en) begin
        stack[nos_i] <= ev_res;
        sp <= sp - SW'(1);
      end else if (push_en) begin
        stack[sp[SI-1:0]] <= push_val;
        sp <= sp + SW'(1);
      end else if (pop_en) begin
        sp <= sp - SW'(1);
      end
    end
  end

  assign busy   = (state == S_CONVERT) || (state == S_FLUSH) || (state == S_EVAL);
  assign valid  = (state == S_DONE);
  assign error  = valid && err;
  assign result = (valid && !err) ? stack[0] : '0;

endmodule

// File: tb/tb_aec_param_calc.sv
module tb_aec_param_calc;

  localparam int W       = 16;
  localparam int MAX_TOK = 32;
  localparam int SDEPTH  = 16;
  localparam int LAT_LIM = 3 * MAX_TOK + 4 + 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ready = 1'b0;
  logic [7:0]   ascii_in = 8'h00;
  logic         busy10, valid10, error10, busy16, valid16, error16;
  logic [W-1:0] result10, result16;

  always #5 clk = ~clk;

  aec_param_calc #(.DATA_W(W), .MAX_TOK(MAX_TOK), .STACK_DEPTH(SDEPTH), .RADIX(10)) dut10 (
    .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
    .busy(busy10), .valid(valid10), .error(error10), .result(result10));

  aec_param_calc #(.DATA_W(W), .MAX_TOK(MAX_TOK), .STACK_DEPTH(SDEPTH), .RADIX(16)) dut16 (
    .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
    .busy(busy16), .valid(valid16), .error(error16), .result(result16));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int pulses10 = 0, pulses16 = 0, exp_pulses10 = 0, exp_pulses16 = 0;
  logic [7:0]  expr_q[$];
  logic [W:0]  exp_q10[$];
  logic [W:0]  exp_q16[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid10) pulses10++;
    if (valid16) pulses16++;
  end

  // ---------------- reference model ----------------
  // Tokenise, shunting-yard, then postfix evaluation over queues.
  // Returns {error, result}.
  function automatic logic [W:0] model(input int radix);
    longint toks[$];
    longint ops[$];
    longint outq[$];
    longint st[$];
    longint acc, a, b, t;
    logic [7:0] c;
    int d;
    bit pend;
    acc = 0; pend = 0;
    foreach (expr_q[i]) begin
      c = expr_q[i];
      d = -1;
      if (c >= "0" && c <= "9") d = int'(c) - 48;
      else if (radix == 16 && c >= "a" && c <= "f") d = int'(c) - 87;
      if (d >= 0) begin
        acc = (acc * radix + d) % 65536;
        pend = 1;
      end else if (c == "+" || c == "-" || c == "*" || c == "(" || c == ")" ||
                   c == " " || c == "=") begin
        if (pend) toks.push_back(acc);
        acc = 0; pend = 0;
        if (c != " " && c != "=") toks.push_back(-longint'(c));
        if (c == "=") break;
      end else begin
        return {1'b1, 16'h0};
      end
    end
    if (toks.size() > MAX_TOK) return {1'b1, 16'h0};
    foreach (toks[i]) begin
      t = toks[i];
      if (t >= 0) outq.push_back(t);
      else if (t == -40) begin
        if (ops.size() == SDEPTH) return {1'b1, 16'h0};
        ops.push_back(t);
      end else if (t == -41) begin
        while (ops.size() > 0 && ops[$] != -40) outq.push_back(ops.pop_back());
        if (ops.size() == 0) return {1'b1, 16'h0};
        void'(ops.pop_back());
      end else begin
        while (ops.size() > 0 && ops[$] != -40 &&
               ((ops[$] == -42) || (t != -42))) outq.push_back(ops.pop_back());
        if (ops.size() == SDEPTH) return {1'b1, 16'h0};
        ops.push_back(t);
      end
    end
    while (ops.size() > 0) begin
      if (ops[$] == -40) return {1'b1, 16'h0};
      outq.push_back(ops.pop_back());
    end
    foreach (outq[i]) begin
      t = outq[i];
      if (t >= 0) begin
        if (st.size() == SDEPTH) return {1'b1, 16'h0};
        st.push_back(t);
      end else begin
        if (st.size() < 2) return {1'b1, 16'h0};
        b = st.pop_back();
        a = st.pop_back();
        if (t == -43)      st.push_back((a + b) & 64'hFFFF);
        else if (t == -45) st.push_back((a - b) & 64'hFFFF);
        else               st.push_back((a * b) & 64'hFFFF);
      end
    end
    if (st.size() != 1) return {1'b1, 16'h0};
    return {1'b0, 16'(st[0])};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load(input string s);
    expr_q.delete();
    for (int i = 0; i < s.len(); i++) expr_q.push_back(s[i]);
  endtask

  task automatic gen_expr();
    string dig = "0123456789abcdef";
    string opc = "+-*";
    int nt, nd, depth;
    expr_q.delete();
    nt = $urandom_range(1, 5);
    depth = 0;
    for (int t = 0; t < nt; t++) begin
      if ($urandom_range(0, 3) == 0) begin expr_q.push_back("("); depth++; end
      nd = $urandom_range(1, 3);
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 11) == 0) expr_q.push_back(dig[$urandom_range(10, 15)]);
        else expr_q.push_back(dig[$urandom_range(0, 9)]);
        if ($urandom_range(0, 15) == 0) expr_q.push_back(" ");
      end
      if (depth > 0 && $urandom_range(0, 1) == 0) begin expr_q.push_back(")"); depth--; end
      if (t < nt - 1) expr_q.push_back(opc[$urandom_range(0, 2)]);
    end
    while (depth > 0) begin
      if ($urandom_range(0, 7) != 0) expr_q.push_back(")");
      depth--;
    end
    if ($urandom_range(0, 19) == 0) expr_q.push_back("#");
    expr_q.push_back("=");
  endtask

  // Sends expr_q, then waits for the result of both instances while
  // spraying junk characters that must be ignored while busy.
  task automatic run_expr(input logic [W:0] e10, input logic [W:0] e16);
    string junk = "0123456789+-*()= #a";
    bit got10, got16, bb10, bb16;
    logic [W:0] o10, o16, x;
    int cyc;
    exp_q10.push_back(e10);
    exp_q16.push_back(e16);
    bb10 = 0; bb16 = 0; got10 = 0; got16 = 0; o10 = '0; o16 = '0;
    foreach (expr_q[i]) begin
      @(negedge clk);
      if (busy10 || valid10) bb10 = 1;
      if (busy16 || valid16) bb16 = 1;
      ready = 1'b1;
      ascii_in = expr_q[i];
    end
    cyc = 0;
    while (!(got10 && got16) && cyc < LAT_LIM) begin
      @(negedge clk);
      cyc++;
      if (!got10) begin
        if (valid10) begin got10 = 1; o10 = {error10, result10}; if (busy10) bb10 = 1; end
        else if (!busy10) bb10 = 1;
      end
      if (!got16) begin
        if (valid16) begin got16 = 1; o16 = {error16, result16}; if (busy16) bb16 = 1; end
        else if (!busy16) bb16 = 1;
      end
      if (busy10 && busy16) begin
        ready = 1'b1;
        ascii_in = junk[$urandom_range(0, junk.len() - 1)];
      end else begin
        ready = 1'b0;
      end
    end
    ready = 1'b0;
    check("done10", 32'(got10), 1);
    check("done16", 32'(got16), 1);
    x = exp_q10.pop_front();
    if (got10) begin
      exp_pulses10++;
      check("err10", 32'(o10[W]), 32'(x[W]));
      check("res10", 32'(o10[W-1:0]), 32'(x[W-1:0]));
    end
    x = exp_q16.pop_front();
    if (got16) begin
      exp_pulses16++;
      check("err16", 32'(o16[W]), 32'(x[W]));
      check("res16", 32'(o16[W-1:0]), 32'(x[W-1:0]));
    end
    check("busy10", 32'(bb10), 0);
    check("busy16", 32'(bb16), 0);
  endtask

  task automatic run_dir(input string s, input logic [W:0] e10, input logic [W:0] e16);
    load(s);
    run_expr(e10, e16);
  endtask

  localparam logic [W:0] ERR = {1'b1, 16'h0};

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {valid10, valid16}, 0);
    check("rst_busy",  {busy10, busy16}, 0);
    check("rst_error", {error10, error16}, 0);
    check("rst_result", {result10, result16}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_dir("12+3*4=",      {1'b0, 16'd24},     {1'b0, 16'h001E});
    run_dir("(1+2)*(3+4)=", {1'b0, 16'd21},     {1'b0, 16'd21});
    run_dir("8-2-3=",       {1'b0, 16'd3},      {1'b0, 16'd3});
    run_dir("2-5=",         {1'b0, 16'hFFFD},   {1'b0, 16'hFFFD});
    run_dir("ff*2=",        ERR,                {1'b0, 16'h01FE});
    run_dir("1 0+1=",       ERR,                ERR);
    run_dir("(1+2=",        ERR,                ERR);
    run_dir("1+2)=",        ERR,                ERR);
    run_dir("1+=",          ERR,                ERR);
    run_dir("3#=",          ERR,                ERR);
    run_dir("=",            ERR,                ERR);
    run_dir("+=",           ERR,                ERR);
    run_dir("99999=",       {1'b0, 16'h869F},   {1'b0, 16'h9999});
    run_dir("5=",           {1'b0, 16'd5},      {1'b0, 16'd5});
    run_dir("6*7=",         {1'b0, 16'd42},     {1'b0, 16'd42});

    // 31 tokens (fits) and 33 tokens (one more than the buffer holds)
    expr_q.delete();
    for (int i = 0; i < 15; i++) begin expr_q.push_back("1"); expr_q.push_back("+"); end
    expr_q.push_back("1"); expr_q.push_back("=");
    run_expr({1'b0, 16'd16}, {1'b0, 16'd16});
    expr_q.delete();
    for (int i = 0; i < 16; i++) begin expr_q.push_back("1"); expr_q.push_back("+"); end
    expr_q.push_back("1"); expr_q.push_back("=");
    run_expr(ERR, ERR);

    // Reset in the middle of conversion
    load("9*9=");
    foreach (expr_q[i]) begin
      @(negedge clk);
      ready = 1'b1;
      ascii_in = expr_q[i];
    end
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {busy10, busy16}, 2'b11);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {valid10, valid16}, 0);
    check("mid_rst_busy", {busy10, busy16}, 0);
    check("mid_rst_out", {error10, error16, result10, result16}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_dir("7=", {1'b0, 16'd7}, {1'b0, 16'd7});

    // Randomised expressions against the reference model
    for (int n = 0; n < 40; n++) begin
      gen_expr();
      run_expr(model(10), model(16));
    end

    repeat (3) @(negedge clk);
    check("pulses10", 32'(pulses10), 32'(exp_pulses10));
    check("pulses16", 32'(pulses16), 32'(exp_pulses16));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
